abs_diff_approx_pipe: RTL and testbench

Pipelined, parametrised absolute-difference unit and the sequential successor to the fixed 2-bit approximate abs-diff netlists. It computes |a − b| per sample, either exactly or with a bounded approximation: the low DROP bits are forced to zero, so the error stays within the error threshold ET. It also accumulates a sum of absolute differences (SAD) over fixed-length frames and self-checks the approximation error. It sits between a streaming operand source and a downstream consumer, with valid/ready flow control on both sides.

---
 rtl/abs_diff_approx_pipe.sv | 117 +++++++++++
 tb/tb_abs_diff_approx_pipe.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/abs_diff_approx_pipe.sv
// Two-stage abs-diff unit with optional LSB truncation.
// Accumulates per-frame SAD and counts out-of-bound errors.
module abs_diff_approx_pipe #(
   parameter int WIDTH = 8,
   parameter int DROP  = 2,
   parameter int ET    = 3,
   parameter int FRAME = 4,
   parameter int ACC_W = WIDTH + $clog2(FRAME)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             approx_en,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_diff,
   output logic [ACC_W-1:0] out_sad,
   output logic             out_last,
   output logic [15:0]      err_cnt
);

   localparam int CW = $clog2(FRAME);
   localparam logic [WIDTH-1:0] LSB_M = WIDTH'((1 << DROP) - 1);
   localparam logic [CW-1:0] LAST_C = CW'(FRAME - 1);

   if (ET < (1 << DROP) - 1) begin : g_bad_et
      $error("ET must be at least 2^DROP-1");
   end

   logic             r_v1;
   logic [WIDTH-1:0] r_a1;
   logic [WIDTH-1:0] r_b1;
   logic             r_m1;
   logic             r_v2;
   logic [WIDTH-1:0] r_diff;
   logic [ACC_W-1:0] r_sad;
   logic             r_last;
   logic [CW-1:0]    r_cnt;
   logic [15:0]      r_err;

   logic             w_en1;
   logic             w_en2;
   logic [WIDTH-1:0] w_exact;
   logic [WIDTH-1:0] w_out;
   logic [WIDTH-1:0] w_gap;
   logic             w_hit;
   logic [ACC_W-1:0] w_sad;

   assign w_en2    = !r_v2 || out_ready;
   assign w_en1    = !r_v1 || w_en2;
   assign in_ready = w_en1 && !clear;

   assign w_exact = (r_a1 >= r_b1) ? r_a1 - r_b1 : r_b1 - r_a1;
   assign w_out   = r_m1 ? (w_exact & ~LSB_M) : w_exact;
   assign w_gap   = w_exact - w_out;
   assign w_hit   = int'(w_gap) > ET;
   // First sample of a frame restarts the sum instead of adding to it
   assign w_sad   = ((r_cnt == '0) ? '0 : r_sad) + ACC_W'(w_out);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v1 <= 1'b0;
         r_a1 <= '0;
         r_b1 <= '0;
         r_m1 <= 1'b0;
      end else if (clear) begin
         r_v1 <= 1'b0;
      end else if (w_en1) begin
         r_v1 <= in_valid;
         if (in_valid) begin
            r_a1 <= in_a;
            r_b1 <= in_b;
            r_m1 <= approx_en;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v2   <= 1'b0;
         r_diff <= '0;
         r_sad  <= '0;
         r_last <= 1'b0;
         r_cnt  <= '0;
         r_err  <= '0;
      end else if (clear) begin
         r_v2   <= 1'b0;
         r_diff <= '0;
         r_sad  <= '0;
         r_last <= 1'b0;
         r_cnt  <= '0;
         r_err  <= '0;
      end else if (w_en2) begin
         r_v2 <= r_v1;
         if (r_v1) begin
            r_diff <= w_out;
            r_sad  <= w_sad;
            r_last <= (r_cnt == LAST_C);
            r_cnt  <= (r_cnt == LAST_C) ? '0 : r_cnt + 1'b1;
            if (w_hit && r_err != 16'hFFFF) begin
               r_err <= r_err + 16'd1;
            end
         end
      end
   end

   assign out_valid = r_v2;
   assign out_diff  = r_diff;
   assign out_sad   = r_sad;
   assign out_last  = r_last;
   assign err_cnt   = r_err;

endmodule

// File: tb/tb_abs_diff_approx_pipe.sv
// Bench for abs_diff_approx_pipe: queue scoreboard fed on accept,
// drained by a monitor on the falling edge.
module tb_abs_diff_approx_pipe;

   typedef struct packed {
      logic [7:0] d;
      logic [9:0] s;
      logic       l;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clear = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_a = '0;
   logic [7:0] in_b = '0;
   logic       approx_en = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [7:0] out_diff;
   logic [9:0] out_sad;
   logic       out_last;
   logic [15:0] err_cnt;

   int n_checks = 0;
   int n_fail = 0;
   exp_t q[$];
   int m_cnt = 0;
   logic [9:0] m_acc = '0;

   always #5 clk = ~clk;

   abs_diff_approx_pipe dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .approx_en (approx_en),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_diff  (out_diff),
      .out_sad   (out_sad),
      .out_last  (out_last),
      .err_cnt   (err_cnt)
   );

   function automatic logic [7:0] mdiff(logic [7:0] a, logic [7:0] b,
                                        logic m);
      logic [7:0] d;
      d = (a >= b) ? a - b : b - a;
      if (m) d = d & 8'hFC;
      return d;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && out_valid && out_ready) begin
         n_checks++;
         if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_output diff=%0d sad=%0d", out_diff,
                     out_sad);
         end else begin
            e = q.pop_front();
            if (out_diff !== e.d) begin
               n_fail++;
               $display("FAIL out_diff got %0d want %0d", out_diff, e.d);
            end
            n_checks++;
            if (out_sad !== e.s) begin
               n_fail++;
               $display("FAIL out_sad got %0d want %0d", out_sad, e.s);
            end
            n_checks++;
            if (out_last !== e.l) begin
               n_fail++;
               $display("FAIL out_last got %0b want %0b", out_last, e.l);
            end
            n_checks++;
            if (err_cnt !== 16'd0) begin
               n_fail++;
               $display("FAIL err_cnt got %0d want 0", err_cnt);
            end
         end
      end
   end

   task automatic model_reset();
      q.delete();
      m_cnt = 0;
      m_acc = '0;
   endtask

   task automatic send(input logic [7:0] a, input logic [7:0] b,
                       input logic m);
      int t;
      logic acc;
      exp_t e;
      in_valid = 1'b1;
      in_a = a;
      in_b = b;
      approx_en = m;
      t = 0;
      acc = 1'b0;
      while (!acc && t < 100) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         t++;
      end
      in_valid = 1'b0;
      if (!acc) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout got no in_ready want accept");
      end else begin
         e.d = mdiff(a, b, m);
         m_acc = (m_cnt == 0) ? 10'(e.d) : m_acc + 10'(e.d);
         e.s = m_acc;
         e.l = (m_cnt == 3);
         m_cnt = (m_cnt == 3) ? 0 : m_cnt + 1;
         q.push_back(e);
      end
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while (q.size() != 0 && t < 100) begin
         @(posedge clk);
         t++;
      end
      #1;
      n_checks++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain got %0d pending want 0", q.size());
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      n_checks++;
      if ({out_valid, out_diff, out_sad, out_last, err_cnt} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs got v=%0b d=%0d s=%0d l=%0b e=%0d want 0",
                  out_valid, out_diff, out_sad, out_last, err_cnt);
      end
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_in_ready got %0b want 1", in_ready);
      end
   endtask

   task automatic test_exact();
      send(8'd200, 8'd37, 1'b0);
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL latency_early got out_valid=%0b want 0", out_valid);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || out_diff !== 8'd163) begin
         n_fail++;
         $display("FAIL latency_result got v=%0b d=%0d want v=1 d=163",
                  out_valid, out_diff);
      end
      send(8'd5, 8'd9, 1'b0);
      wait_drain();
   endtask

   task automatic test_approx();
      send(8'd200, 8'd37, 1'b1);
      send(8'd0, 8'd255, 1'b1);
      send(8'd3, 8'd3, 1'b1);
      wait_drain();
      n_checks++;
      if (out_diff !== 8'd0 || err_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL approx_tail got d=%0d e=%0d want d=0 e=0",
                  out_diff, err_cnt);
      end
   endtask

   task automatic test_frame();
      do_reset();
      send(8'd200, 8'd37, 1'b0);
      send(8'd5, 8'd9, 1'b0);
      send(8'd7, 8'd7, 1'b0);
      send(8'd255, 8'd0, 1'b0);
      send(8'd20, 8'd10, 1'b0);
      wait_drain();
      n_checks++;
      if (out_sad !== 10'd10 || out_last !== 1'b0) begin
         n_fail++;
         $display("FAIL frame_wrap got s=%0d l=%0b want s=10 l=0",
                  out_sad, out_last);
      end
   endtask

   task automatic test_back_to_back();
      logic [18:0] snap;
      do_reset();
      fork
         begin
            send(8'd10, 8'd1, 1'b0);
            send(8'd1, 8'd30, 1'b1);
            send(8'd99, 8'd0, 1'b0);
            send(8'd64, 8'd64, 1'b0);
            send(8'd0, 8'd77, 1'b1);
            send(8'd250, 8'd5, 1'b0);
         end
         begin
            repeat (3) @(posedge clk);
            #1;
            out_ready = 1'b0;
            @(negedge clk);
            snap = {out_valid, out_diff, out_sad};
            for (int i = 0; i < 3; i++) begin
               if (i > 0) @(negedge clk);
               n_checks++;
               if ({out_valid, out_diff, out_sad} !== snap ||
                   out_valid !== 1'b1) begin
                  n_fail++;
                  $display("FAIL stall_hold got %h want %h", {out_valid,
                           out_diff, out_sad}, snap);
               end
               n_checks++;
               if (in_ready !== 1'b0) begin
                  n_fail++;
                  $display("FAIL stall_in_ready got %0b want 0", in_ready);
               end
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      wait_drain();
   endtask

   task automatic test_clear();
      do_reset();
      send(8'd200, 8'd37, 1'b0);
      send(8'd5, 8'd9, 1'b0);
      send(8'd7, 8'd7, 1'b0);
      send(8'd255, 8'd0, 1'b0);
      send(8'd50, 8'd10, 1'b0);
      send(8'd10, 8'd50, 1'b1);
      wait_drain();
      clear = 1'b1;
      in_valid = 1'b1;
      in_a = 8'd123;
      in_b = 8'd1;
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL clear_in_ready got %0b want 0", in_ready);
      end
      @(posedge clk);
      #1;
      clear = 1'b0;
      in_valid = 1'b0;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_flush got out_valid=%0b want 0", out_valid);
         end
         @(posedge clk);
         #1;
      end
      send(8'd40, 8'd4, 1'b0);
      send(8'd3, 8'd9, 1'b1);
      send(8'd100, 8'd1, 1'b0);
      send(8'd8, 8'd2, 1'b0);
      wait_drain();
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      out_ready = 1'b0;
      send(8'd90, 8'd10, 1'b0);
      send(8'd15, 8'd3, 1'b0);
      @(posedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || out_sad !== 10'd80) begin
         n_fail++;
         $display("FAIL pre_reset got v=%0b s=%0d want v=1 s=80",
                  out_valid, out_sad);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({out_valid, out_diff, out_sad, out_last, err_cnt} !== '0) begin
         n_fail++;
         $display("FAIL async_reset got v=%0b d=%0d s=%0d l=%0b want 0",
                  out_valid, out_diff, out_sad, out_last);
      end
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL post_reset_in_ready got %0b want 1", in_ready);
      end
      send(8'd12, 8'd2, 1'b0);
      send(8'd2, 8'd12, 1'b1);
      send(8'd0, 8'd0, 1'b0);
      send(8'd255, 8'd254, 1'b0);
      wait_drain();
   endtask

   initial begin
      test_reset();
      test_exact();
      test_approx();
      test_frame();
      test_back_to_back();
      test_clear();
      test_reset_mid_stall();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
